// File: rtl/ferc_shift_out.sv
// Serial driver for the front-end relay control chain: shifts one relay word out MSB first
// on ferc_dat/ferc_clk, then strobes ferc_lat. Optional macro FERC_SHADOW_EN skips re-sending an unchanged word.
module ferc_shift_out #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             ferc_dat,
  output logic             ferc_clk,
  output logic             ferc_lat
);

  localparam int unsigned PW = $clog2(PRESCALE + 1);
  localparam int unsigned BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_phase;
  logic [PW-1:0]    w_phase_nxt;
  logic [BW-1:0]    r_bit;
  logic [BW-1:0]    w_bit_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;

  logic r_s_ready;
  logic r_busy;
  logic r_done;
  logic r_ferc_dat;
  logic r_ferc_clk;
  logic r_ferc_lat;

  logic w_ready_nxt;
  logic w_done_nxt;
  logic w_dat_nxt;
  logic w_clk_nxt;
  logic w_lat_nxt;

  logic w_accept;
  logic w_skip;
  logic w_phase_end;
  logic w_last_bit;

  assign w_accept    = s_valid && (r_state == ST_IDLE);
  assign w_phase_end = (r_phase == PW'(PRESCALE - 1));
  assign w_last_bit  = (r_bit == '0);

`ifdef FERC_SHADOW_EN
  // Shadow of the last word that actually reached the latch.
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_valid;

  assign w_skip = r_shadow_valid && (s_data == r_shadow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word         <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else begin
      if (w_accept && !w_skip) begin
        r_word <= s_data;
      end
      if ((r_state == ST_LATCH) && w_phase_end) begin
        r_shadow       <= r_word;
        r_shadow_valid <= 1'b1;
      end
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next state; phase counter restarts on every state change so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_phase_nxt = '0;
        if (w_accept && !w_skip) begin
          w_state_nxt = ST_SHIFT_LO;
          w_bit_nxt   = BW'(WIDTH - 1);
          w_shift_nxt = s_data;
        end
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) begin
          w_state_nxt = ST_SHIFT_HI;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          w_phase_nxt = '0;
          if (w_last_bit) begin
            w_state_nxt = ST_LATCH;
          end else begin
            w_state_nxt = ST_SHIFT_LO;
            w_bit_nxt   = r_bit - BW'(1);
            w_shift_nxt = r_shift << 1;
          end
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      ST_LATCH: begin
        if (w_phase_end) begin
          w_state_nxt = ST_IDLE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + PW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // Pin values are derived from the next state so they are stable from the first cycle of each phase.
  always_comb begin
    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_clk_nxt   = (w_state_nxt == ST_SHIFT_HI);
    w_lat_nxt   = (w_state_nxt == ST_LATCH);
    w_dat_nxt   = 1'b0;
    if ((w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI)) begin
      w_dat_nxt = w_shift_nxt[WIDTH-1];
    end
    w_done_nxt = ((r_state == ST_LATCH) && (w_state_nxt == ST_IDLE)) || (w_accept && w_skip);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_ready  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ferc_dat <= 1'b0;
      r_ferc_clk <= 1'b0;
      r_ferc_lat <= 1'b0;
    end else begin
      r_s_ready  <= w_ready_nxt;
      r_busy     <= !w_ready_nxt;
      r_done     <= w_done_nxt;
      r_ferc_dat <= w_dat_nxt;
      r_ferc_clk <= w_clk_nxt;
      r_ferc_lat <= w_lat_nxt;
    end
  end

  assign s_ready  = r_s_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ferc_dat = r_ferc_dat;
  assign ferc_clk = r_ferc_clk;
  assign ferc_lat = r_ferc_lat;

endmodule

// File: tb/tb_ferc_shift_out.sv
// Bench for ferc_shift_out: timing checks on a PRESCALE=4 and a minimal instance, plus a
// chain model with an expected-word queue on PRESCALE=4 and PRESCALE=1 instances.
module tb_ferc_shift_out;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #2 clk = ~clk;

  // Main instance: WIDTH=16, PRESCALE=4
  logic [15:0] m_data;
  logic        m_valid, m_ready, m_busy, m_done, m_dat, m_fclk, m_lat;
  // Minimal instance: WIDTH=1, PRESCALE=1
  logic [0:0]  n_data;
  logic        n_valid, n_ready, n_busy, n_done, n_dat, n_fclk, n_lat;
  // Fast instance for the long random run: WIDTH=16, PRESCALE=1
  logic [15:0] f_data;
  logic        f_valid, f_ready, f_busy, f_done, f_dat, f_fclk, f_lat;

  ferc_shift_out #(.WIDTH(16), .PRESCALE(4)) u_main (
    .clk(clk), .rst(rst), .s_data(m_data), .s_valid(m_valid), .s_ready(m_ready),
    .busy(m_busy), .done(m_done), .ferc_dat(m_dat), .ferc_clk(m_fclk), .ferc_lat(m_lat));

  ferc_shift_out #(.WIDTH(1), .PRESCALE(1)) u_min (
    .clk(clk), .rst(rst), .s_data(n_data), .s_valid(n_valid), .s_ready(n_ready),
    .busy(n_busy), .done(n_done), .ferc_dat(n_dat), .ferc_clk(n_fclk), .ferc_lat(n_lat));

  ferc_shift_out #(.WIDTH(16), .PRESCALE(1)) u_fast (
    .clk(clk), .rst(rst), .s_data(f_data), .s_valid(f_valid), .s_ready(f_ready),
    .busy(f_busy), .done(f_done), .ferc_dat(f_dat), .ferc_clk(f_fclk), .ferc_lat(f_lat));

  // External chain models: shift on ferc_clk rise, compare against the queue on ferc_lat rise.
  logic [15:0] m_sr = '0, f_sr = '0, m_exp, f_exp;
  logic [15:0] m_q[$];
  logic [15:0] f_q[$];

  always @(posedge m_fclk) m_sr <= {m_sr[14:0], m_dat};
  always @(posedge f_fclk) f_sr <= {f_sr[14:0], f_dat};

  always @(posedge m_lat) begin
    checks++;
    if (m_q.size() == 0) begin
      errors++;
      $display("FAIL main_latch: latched %h but no word expected", m_sr);
    end else begin
      m_exp = m_q.pop_front();
      if (m_sr !== m_exp) begin
        errors++;
        $display("FAIL main_latch: latched %h expected %h", m_sr, m_exp);
      end
    end
  end

  always @(posedge f_lat) begin
    checks++;
    if (f_q.size() == 0) begin
      errors++;
      $display("FAIL fast_latch: latched %h but no word expected", f_sr);
    end else begin
      f_exp = f_q.pop_front();
      if (f_sr !== f_exp) begin
        errors++;
        $display("FAIL fast_latch: latched %h expected %h", f_sr, f_exp);
      end
    end
  end

  // Pin protocol: no clock under latch, data frozen while clock high, busy mirrors ready.
  logic m_pclk = 1'b0, m_pdat = 1'b0, f_pclk = 1'b0, f_pdat = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((m_fclk && m_lat) || (f_fclk && f_lat)) begin
        errors++;
        $display("FAIL clk_under_lat: main %b/%b fast %b/%b required not both high", m_fclk, m_lat, f_fclk, f_lat);
      end
      checks++;
      if ((m_busy !== ~m_ready) || (f_busy !== ~f_ready)) begin
        errors++;
        $display("FAIL busy_ready: main %b/%b fast %b/%b required complementary", m_busy, m_ready, f_busy, f_ready);
      end
      if (m_pclk && m_fclk) begin
        checks++;
        if (m_dat !== m_pdat) begin
          errors++;
          $display("FAIL main_dat_hold: dat %b was %b while ferc_clk high", m_dat, m_pdat);
        end
      end
      if (f_pclk && f_fclk) begin
        checks++;
        if (f_dat !== f_pdat) begin
          errors++;
          $display("FAIL fast_dat_hold: dat %b was %b while ferc_clk high", f_dat, f_pdat);
        end
      end
    end
    m_pclk = m_fclk; m_pdat = m_dat; f_pclk = f_fclk; f_pdat = f_dat;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready_m(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL main_ready_timeout: s_ready %b required 1", m_ready);
    end
  endtask

  // Sends one word on the main instance, returns done offset from T0, ferc_clk rises, ready drop.
  task automatic xfer_m(input logic [15:0] w, output int done_k, output int rises, output bit ready_low);
    bit   ok;
    logic pc;
    wait_ready_m(ok);
    m_data = w; m_valid = 1'b1;
    done_k = -1; rises = 0; ready_low = 1'b0; pc = m_fclk;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) m_valid = 1'b0;
      if (m_fclk && !pc) rises++;
      pc = m_fclk;
      if (m_done === 1'b1) begin
        done_k = k;
        break;
      end
      if (m_ready !== 1'b1) ready_low = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok, saw_lat;
    logic [5:0] got, exp;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp = 6'b100000;
    got = {m_ready, m_busy, m_done, m_dat, m_fclk, m_lat};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state: rdy/busy/done/dat/clk/lat %b required %b", got, exp);
    end
    rst = 1'b0;
    @(negedge clk);
    wait_ready_m(ok);
    m_data = 16'hBEEF; m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (m_fclk !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_hi: ferc_clk %b required 1 at T0+6", m_fclk);
    end
    rst = 1'b1;
    #1;
    got = {m_ready, m_busy, m_done, m_dat, m_fclk, m_lat};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async: rdy/busy/done/dat/clk/lat %b required %b", got, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_lat = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (m_lat !== 1'b0) saw_lat = 1'b1;
    end
    checks++;
    if (m_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: s_ready %b required 1 after release", m_ready);
    end
    checks++;
    if (saw_lat) begin
      errors++;
      $display("FAIL reset_no_latch: ferc_lat pulsed 1 required 0 after abort");
    end
  endtask

  task automatic test_single_word();
    bit ok;
    logic pc;
    logic [15:0] word;
    int rises;
    bit exp_lat, exp_done, exp_rdy, exp_rise, rise;
    wait_ready_m(ok);
    m_data = 16'hA5C3; m_valid = 1'b1;
    m_q.push_back(16'hA5C3);
    pc = 1'b0; word = '0; rises = 0;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m_valid = 1'b0;
        m_data  = 16'h0000;
      end
      rise     = m_fclk && !pc;
      pc       = m_fclk;
      exp_rise = (k >= 5) && (k <= 125) && (((k - 5) % 8) == 0);
      exp_lat  = (k >= 129) && (k < 133);
      exp_done = (k == 133);
      exp_rdy  = (k >= 133);
      if (rise) begin
        word = {word[14:0], m_dat};
        rises++;
      end
      checks++;
      if (rise !== exp_rise) begin
        errors++;
        $display("FAIL single_rise: T0+%0d rise %b required %b", k, rise, exp_rise);
      end
      checks++;
      if ({m_lat, m_done, m_ready} !== {exp_lat, exp_done, exp_rdy}) begin
        errors++;
        $display("FAIL single_timing: T0+%0d lat/done/rdy %b%b%b required %b%b%b",
                 k, m_lat, m_done, m_ready, exp_lat, exp_done, exp_rdy);
      end
    end
    checks++;
    if (word !== 16'hA5C3 || rises != 16) begin
      errors++;
      $display("FAIL single_bits: sampled %h over %0d rises required a5c3 over 16", word, rises);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int done_k;
    wait_ready_m(ok);
    m_data = 16'h1234; m_valid = 1'b1;
    m_q.push_back(16'h1234);
    done_k = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) m_data = 16'hFFFF;
      if (m_done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k != 133 || m_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_first_done: done at T0+%0d rdy %b required T0+133 rdy 1", done_k, m_ready);
    end
    m_q.push_back(16'hFFFF);
    @(negedge clk);
    m_valid = 1'b0;
    checks++;
    if ({m_busy, m_fclk, m_dat} !== 3'b101) begin
      errors++;
      $display("FAIL busy_b2b_start: busy/clk/dat %b%b%b required 101", m_busy, m_fclk, m_dat);
    end
    done_k = -1;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k != 133) begin
      errors++;
      $display("FAIL busy_second_done: done at T0+%0d required T0+133", done_k);
    end
  endtask

  task automatic test_min_prescale();
    logic [4:0] got, exp;
    @(negedge clk);
    n_data = 1'b1; n_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_valid = 1'b0;
      exp = {(k == 1 || k == 2), (k == 2), (k == 3), (k == 4), (k >= 4)};
      got = {n_dat, n_fclk, n_lat, n_done, n_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL min_prescale: T0+%0d dat/clk/lat/done/rdy %b required %b", k, got, exp);
      end
    end
  endtask

  task automatic test_shadow();
    int  dk, rs;
    bit  rl;
    m_q.push_back(16'h00FF);
    xfer_m(16'h00FF, dk, rs, rl);
    checks++;
    if (dk != 133 || rs != 16) begin
      errors++;
      $display("FAIL shadow_first: done T0+%0d rises %0d required 133/16", dk, rs);
    end
`ifdef FERC_SHADOW_EN
    xfer_m(16'h00FF, dk, rs, rl);
    checks++;
    if (dk != 1 || rs != 0 || rl) begin
      errors++;
      $display("FAIL shadow_skip: done T0+%0d rises %0d ready_drop %b required 1/0/0", dk, rs, rl);
    end
`else
    m_q.push_back(16'h00FF);
    xfer_m(16'h00FF, dk, rs, rl);
    checks++;
    if (dk != 133 || rs != 16 || !rl) begin
      errors++;
      $display("FAIL repeat_full: done T0+%0d rises %0d ready_drop %b required 133/16/1", dk, rs, rl);
    end
`endif
    m_q.push_back(16'h00FE);
    xfer_m(16'h00FE, dk, rs, rl);
    checks++;
    if (dk != 133 || rs != 16) begin
      errors++;
      $display("FAIL shadow_change: done T0+%0d rises %0d required 133/16", dk, rs);
    end
    pulse_reset();
    m_q.push_back(16'h00FE);
    xfer_m(16'h00FE, dk, rs, rl);
    checks++;
    if (dk != 133 || rs != 16) begin
      errors++;
      $display("FAIL shadow_after_reset: done T0+%0d rises %0d required 133/16", dk, rs);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [15:0] sh = '0;
    bit          sh_v = 1'b0;
    bit          ok;
    for (int i = 0; i < 1000; i++) begin
      w = 16'($urandom);
      if (i % 50 == 7 && sh_v) w = sh;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      f_data = w; f_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        if (f_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL random_ready_timeout: word %0d s_ready %b required 1", i, f_ready);
        f_valid = 1'b0;
        continue;
      end
`ifdef FERC_SHADOW_EN
      if (!(sh_v && w == sh)) f_q.push_back(w);
`else
      f_q.push_back(w);
`endif
      sh = w; sh_v = 1'b1;
      @(negedge clk);
      f_valid = 1'b0;
    end
    repeat (60) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m_data = '0; m_valid = 1'b0;
    n_data = '0; n_valid = 1'b0;
    f_data = '0; f_valid = 1'b0;
    test_reset();
    test_single_word();
    test_busy_ignore();
    test_min_prescale();
    test_shadow();
    test_random();
    checks++;
    if (m_q.size() != 0 || f_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d main and %0d fast words never latched required 0", m_q.size(), f_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
